// File: rtl/hamming_encoder.sv
// hamming_encoder: encodes a 64-bit message into a 128-bit SEC codeword, LANES bytes per clock, with optional single-bit injection
module hamming_encoder #(
  parameter int LANES = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [63:0]  msg_in,
  input  logic         msg_valid,
  output logic         msg_ready,
  input  logic         inj_en,
  input  logic [6:0]   inj_pos,
  output logic [127:0] code_out,
  output logic         code_valid,
  input  logic         code_ready,
  output logic         busy,
  output logic [15:0]  words_sent
);
  localparam int NGRP = 8 / LANES;
  typedef enum logic [1:0] {IDLE, ENCODE, DONE} state_t;
  state_t state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [63:0] msg_q, msg_d;
  logic inj_en_q, inj_en_d;
  logic [6:0] inj_pos_q, inj_pos_d;
  logic [127:0] code_q, code_d;
  logic [15:0] words_q, words_d;
  int blk;
  function automatic logic [15:0] enc(input logic [7:0] d);
    logic [15:0] b;
    b = '0;
    {b[12], b[10], b[9], b[8], b[6], b[5], b[4], b[3]} = d;
    b[14] = b[12] ^ b[10] ^ b[8] ^ b[6] ^ b[4];
    b[13] = b[12] ^ b[9] ^ b[8] ^ b[5] ^ b[4];
    b[11] = b[10] ^ b[9] ^ b[8] ^ b[3];
    b[7]  = b[6] ^ b[5] ^ b[4] ^ b[3];
    b[15] = ^b[14:0];
    return b;
  endfunction
  // next-state: accept in IDLE, write one lane group per ENCODE cycle, hand off in DONE
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    msg_d     = msg_q;
    inj_en_d  = inj_en_q;
    inj_pos_d = inj_pos_q;
    code_d    = code_q;
    words_d   = words_q;
    blk       = 0;
    if (state_q == IDLE) begin
      if (msg_valid) begin
        msg_d     = msg_in;
        inj_en_d  = inj_en;
        inj_pos_d = inj_pos;
        idx_d     = 3'd0;
        state_d   = ENCODE;
      end
    end else if (state_q == ENCODE) begin
      for (int l = 0; l < LANES; l++) begin
        blk = int'(idx_q) * LANES + l;
        code_d[blk*16 +: 16] = enc(msg_q[blk*8 +: 8]) ^
          ((inj_en_q && int'(inj_pos_q[6:4]) == blk) ? (16'd1 << inj_pos_q[3:0]) : 16'd0);
      end
      idx_d   = idx_q + 3'd1;
      state_d = (idx_q == 3'(NGRP - 1)) ? DONE : ENCODE;
    end else if (code_ready) begin
      words_d = (words_q == 16'hFFFF) ? words_q : words_q + 16'd1;
      state_d = IDLE;
    end
  end
  // state registers, cleared asynchronously so a reset aborts any word in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      msg_q     <= '0;
      inj_en_q  <= 1'b0;
      inj_pos_q <= '0;
      code_q    <= '0;
      words_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      msg_q     <= msg_d;
      inj_en_q  <= inj_en_d;
      inj_pos_q <= inj_pos_d;
      code_q    <= code_d;
      words_q   <= words_d;
    end
  end
  assign msg_ready  = state_q == IDLE;
  assign code_valid = state_q == DONE;
  assign busy       = state_q != IDLE;
  assign code_out   = code_q;
  assign words_sent = words_q;
endmodule

// File: tb/tb_hamming_encoder.sv
// tb_hamming_encoder: directed vector checks of the encoder at LANES=1 and LANES=8
module tb_hamming_encoder;
  logic clk = 0, rst = 1;
  logic [63:0] msg_in = '0;
  logic mv1 = 0, mv8 = 0, inj_en = 0, code_ready = 0;
  logic [6:0] inj_pos = '0;
  logic mr1, mr8, cv1, cv8, busy1, busy8;
  logic [127:0] co1, co8;
  logic [15:0] ws1, ws8;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  hamming_encoder #(.LANES(1)) u1 (.clk(clk), .rst(rst), .msg_in(msg_in), .msg_valid(mv1), .msg_ready(mr1),
    .inj_en(inj_en), .inj_pos(inj_pos), .code_out(co1), .code_valid(cv1), .code_ready(code_ready),
    .busy(busy1), .words_sent(ws1));
  hamming_encoder #(.LANES(8)) u8 (.clk(clk), .rst(rst), .msg_in(msg_in), .msg_valid(mv8), .msg_ready(mr8),
    .inj_en(inj_en), .inj_pos(inj_pos), .code_out(co8), .code_valid(cv8), .code_ready(code_ready),
    .busy(busy8), .words_sent(ws8));
  typedef struct {
    logic [63:0]  msg;
    logic         inj;
    logic [6:0]   pos;
    logic [127:0] exp;
  } vec_t;
  vec_t vecs[10];
  logic [15:0] exp_words = 0;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // returns clocks from accept edge to code_valid; code_ready must be set by caller
  task automatic send(input bit wide, input logic [63:0] m, input logic ie, input logic [6:0] ip, output int lat);
    int n = 0;
    while (!(wide ? mr8 : mr1) && n < 20) begin tick(); n++; end
    chk("msg_ready_before_send", 128'(wide ? mr8 : mr1), 128'd1);
    msg_in = m; inj_en = ie; inj_pos = ip;
    if (wide) mv8 = 1; else mv1 = 1;
    tick();
    mv1 = 0; mv8 = 0; inj_en = 0;
    n = 0;
    while (!(wide ? cv8 : cv1) && n < 20) begin tick(); n++; end
    lat = n;
  endtask
  function automatic logic [3:0] syn(input logic [15:0] b);
    return {b[7] ^ b[6] ^ b[5] ^ b[4] ^ b[3],
            b[11] ^ b[10] ^ b[9] ^ b[8] ^ b[3],
            b[13] ^ b[12] ^ b[9] ^ b[8] ^ b[5] ^ b[4],
            b[14] ^ b[12] ^ b[10] ^ b[8] ^ b[6] ^ b[4]};
  endfunction
  initial begin
    int lat;
    logic [127:0] held;
    vecs[0] = '{64'h0,                 0, 7'd0,   128'h0};
    vecs[1] = '{64'h80,                0, 7'd0,   128'hF000};
    vecs[2] = '{64'h01,                0, 7'd0,   128'h8888};
    vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 0, 7'd0, {8{16'h7778}}};
    vecs[4] = '{64'h0,                 1, 7'd12,  128'h1000};
    vecs[5] = '{64'h40,                0, 7'd0,   128'hCC00};
    vecs[6] = '{64'h8001,              0, 7'd0,   128'hF000_8888};
    vecs[7] = '{64'h80,                1, 7'd0,   128'hF001};
    vecs[8] = '{64'h0,                 1, 7'd127, {16'h8000, 112'h0}};
    vecs[9] = '{64'h0100,              1, 7'd31,  128'h0888_0000};
    #2;
    chk("reset_code_valid", 128'(cv1), 128'd0);
    chk("reset_code_out", co1, 128'd0);
    chk("reset_words", 128'(ws1), 128'd0);
    chk("reset_msg_ready", 128'(mr1), 128'd1);
    #10 rst = 0;
    tick();
    // abort by reset during the 4th ENCODE cycle
    msg_in = 64'hFFFF_FFFF_FFFF_FFFF; mv1 = 1;
    tick();
    mv1 = 0;
    tick(); tick(); tick();
    chk("abort_busy_before", 128'(busy1), 128'd1);
    rst = 1;
    #1;
    chk("abort_code_valid", 128'(cv1), 128'd0);
    tick();
    rst = 0;
    #1;
    chk("abort_msg_ready", 128'(mr1), 128'd1);
    chk("abort_words", 128'(ws1), 128'd0);
    chk("abort_code_out", co1, 128'd0);
    for (int i = 0; i < 10; i++) begin tick(); chk("abort_no_valid", 128'(cv1), 128'd0); end
    // table-driven vectors, LANES=1
    code_ready = 1;
    for (int i = 0; i < 10; i++) begin
      send(0, vecs[i].msg, vecs[i].inj, vecs[i].pos, lat);
      chk($sformatf("latency1_v%0d", i), 128'(lat), 128'd8);
      chk($sformatf("code1_v%0d", i), co1, vecs[i].exp);
      chk($sformatf("msg_ready_done_v%0d", i), 128'(mr1), 128'd0);
      tick();
      exp_words++;
      chk($sformatf("valid_drop_v%0d", i), 128'(cv1), 128'd0);
      chk($sformatf("words_v%0d", i), 128'(ws1), 128'(exp_words));
      if (i == 4) begin
        chk("decode_syndrome_blk0", 128'(syn(co1[15:0])), 128'd3);
        chk("decode_data_blk0", 128'({co1[12], co1[10:8], co1[6:3]} ^ 8'h80), 128'd0);
      end
    end
    // LANES=8 path
    send(1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 7'd0, lat);
    chk("latency8_ones", 128'(lat), 128'd1);
    chk("code8_ones", co8, {8{16'h7778}});
    tick();
    send(1, 64'h80, 1, 7'd127, lat);
    chk("latency8_inj", 128'(lat), 128'd1);
    chk("code8_inj", co8, {16'h8000, 112'hF000});
    tick();
    chk("words8", 128'(ws8), 128'd2);
    // backpressure: hold in DONE, ignore msg_valid and code_ready elsewhere
    code_ready = 0;
    send(0, 64'h01, 0, 7'd0, lat);
    held = co1;
    chk("bp_code", held, 128'h8888);
    for (int i = 0; i < 5; i++) begin
      msg_in = 64'hDEAD_BEEF_0000_0080 + 64'(i); mv1 = i[0];
      tick();
      chk("bp_valid", 128'(cv1), 128'd1);
      chk("bp_stable", co1, held);
      chk("bp_msg_ready", 128'(mr1), 128'd0);
      chk("bp_words", 128'(ws1), 128'(exp_words));
    end
    mv1 = 0; code_ready = 1;
    tick();
    exp_words++;
    chk("bp_release_valid", 128'(cv1), 128'd0);
    chk("bp_release_words", 128'(ws1), 128'(exp_words));
    chk("bp_release_ready", 128'(mr1), 128'd1);
    tick();
    chk("bp_no_latch", 128'(busy1), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
